// File: rtl/dreq_credits_rd_pkg.sv
// Shared types for the read-request credit gate: the request descriptor layout and beat sizing.
package dreq_credits_rd_pkg;

    localparam int AXI_DATA_BITS = 512;
    localparam int BEAT_LOG_BITS = $clog2(AXI_DATA_BITS / 8);
    localparam int LEN_BITS      = 28;
    localparam int VADDR_BITS    = 48;
    localparam int PID_BITS      = 6;

    typedef struct packed {
        logic [VADDR_BITS-1:0] vaddr;
        logic [LEN_BITS-1:0]   len;
        logic [PID_BITS-1:0]   pid;
        logic                  last;
    } req_t;

    typedef struct packed {
        req_t req_1;
        req_t req_2;
    } dreq_t;

endpackage

// File: rtl/dreq_credits_rd_len_fifo.sv
// Small synchronous FIFO holding the beat count of each request still in flight.
module dreq_credits_rd_len_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wrPtr_q, wrPtr_d;
    logic [AW:0]  rdPtr_q, rdPtr_d;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign head  = mem[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push && !full) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop && !empty) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrPtr_q[AW-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/dreq_credits_rd.sv
// Read-request credit gate: forwards a request only when the region's read-data queue can hold its whole response.
module dreq_credits_rd
    import dreq_credits_rd_pkg::*;
#(
    parameter int DATA_BITS     = AXI_DATA_BITS,
    parameter int CRED_DEPTH    = 32,
    parameter int N_OUTSTANDING = 8,
    localparam int CW = $clog2(CRED_DEPTH) + 1,
    localparam int OW = $clog2(N_OUTSTANDING) + 1
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          s_req_valid,
    output logic          s_req_ready,
    input  dreq_t         s_req_data,
    output logic          m_req_valid,
    input  logic          m_req_ready,
    output dreq_t         m_req_data,
    input  logic          xfer,
    output logic          done,
    output logic [CW-1:0] credits,
    output logic [OW-1:0] outstanding,
    output logic          err
);

    localparam int NBW = LEN_BITS + 1;
    localparam int BLB = $clog2(DATA_BITS / 8);
    localparam logic [CW-1:0]  CRED_MAX = CW'(CRED_DEPTH);
    localparam logic [OW-1:0]  OUT_MAX  = OW'(N_OUTSTANDING);
    localparam logic [NBW-1:0] BEAT_RND = NBW'((1 << BLB) - 1);

    logic [CW-1:0]  credits_q, credits_d;
    logic [OW-1:0]  outstanding_q, outstanding_d;
    logic [CW-1:0]  remaining_q, remaining_d;
    logic           done_q, err_q, err_d;
    logic [NBW-1:0] nBeats;
    logic           accept, intReady, xferOk, credFull, pop;
    logic [CW-1:0]  head;
    logic           fifoFull, fifoEmpty;

    logic  outValid_q, outValid_d, skidValid_q, skidValid_d;
    dreq_t outData_q, outData_d, skidData_q, skidData_d;

    // One bit of headroom over the length field so the ceiling add cannot wrap.
    assign nBeats = ({1'b0, s_req_data.req_2.len} + BEAT_RND) >> BLB;

    assign accept = s_req_valid && intReady && !fifoFull
                 && (NBW'(credits_q) >= nBeats)
                 && (outstanding_q < OUT_MAX)
                 && (nBeats != '0);
    assign s_req_ready = accept;
    assign intReady    = !skidValid_q;
    assign xferOk      = xfer && !fifoEmpty;
    assign credFull    = (credits_q == CRED_MAX);

    dreq_credits_rd_len_fifo #(
        .W     (CW),
        .DEPTH (N_OUTSTANDING)
    ) uLenFifo (
        .clk      (aclk),
        .reset    (areset),
        .push     (accept),
        .pushData (nBeats[CW-1:0]),
        .pop      (pop),
        .head     (head),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_comb begin
        remaining_d = remaining_q;
        pop         = 1'b0;
        if (xferOk) begin
            if (remaining_q == '0) begin
                if (head == CW'(1)) begin
                    pop = 1'b1;
                end else begin
                    remaining_d = head - 1'b1;
                end
            end else begin
                remaining_d = remaining_q - 1'b1;
                pop         = (remaining_q == CW'(1));
            end
        end
        credits_d     = credits_q - (accept ? nBeats[CW-1:0] : '0)
                                  + ((xferOk && !credFull) ? CW'(1) : '0);
        outstanding_d = outstanding_q + (accept ? OW'(1) : '0) - (pop ? OW'(1) : '0);
        err_d         = err_q
                      | (xfer && (fifoEmpty || credFull))
                      | (s_req_valid && ((nBeats == '0) || (nBeats > NBW'(CRED_DEPTH))));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            credits_q     <= CRED_MAX;
            outstanding_q <= '0;
            remaining_q   <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            credits_q     <= credits_d;
            outstanding_q <= outstanding_d;
            remaining_q   <= remaining_d;
            done_q        <= pop;
            err_q         <= err_d;
        end
    end

    // Two-entry output slice: the skid entry lets upstream ready come from a register, not from m_req_ready.
    always_comb begin
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        if (!outValid_q || m_req_ready) begin
            if (skidValid_q) begin
                outValid_d  = 1'b1;
                outData_d   = skidData_q;
                skidValid_d = 1'b0;
            end else begin
                outValid_d = accept;
                if (accept) begin
                    outData_d = s_req_data;
                end
            end
        end else if (accept) begin
            skidValid_d = 1'b1;
            skidData_d  = s_req_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            outValid_q  <= 1'b0;
            skidValid_q <= 1'b0;
        end else begin
            outValid_q  <= outValid_d;
            skidValid_q <= skidValid_d;
        end
    end

    always_ff @(posedge aclk) begin
        outData_q  <= outData_d;
        skidData_q <= skidData_d;
    end

    assign m_req_valid = outValid_q;
    assign m_req_data  = outData_q;
    assign done        = done_q;
    assign credits     = credits_q;
    assign outstanding = outstanding_q;
    assign err         = err_q;

endmodule
